alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor of the single-cycle datapath ALU. It executes logic, arithmetic and compare ops in one cycle. Shifts run iteratively, one bit per cycle; there is no barrel shifter. An optional iterative shift-add multiply can be compiled in. It sits between the register-file read stage and writeback, and stalls the issue stage through valid/ready.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands and Aluop valid this cycle
in_ready  output  1  block can accept an op this cycle
op1  input  WIDTH  first operand
op2  input  WIDTH  second operand; shift amount for SHL/SHR
Aluop  input  4  operation select
out_valid  output  1  result/flags valid
out_ready  input  1  consumer takes result this cycle
result  output  WIDTH  registered result
equal  output  1  registered equality flag
lessThan  output  1  registered unsigned less-than flag
carry  output  1  ADD carry-out / SUB borrow

Behaviour:
- Reset (async, active-high), all registered: state=IDLE, out_valid=0, result=0, equal=0, lessThan=0, carry=0, counter=0. in_ready=1 once reset deasserts.
- Accept occurs when in_valid && in_ready. op1, op2 and Aluop are latched at accept; later input changes are ignored.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR
  - 0011 ADD: carry = bit WIDTH of the sum
  - 0100 SUB: carry = (op1<op2)
  - 0101 SLT: lessThan = op1<op2
  - 0110 SLTE: lessThan = op1<=op2, equal = op1==op2
  - 0111 EQ: equal = op1==op2
  - 1000 SHL logical, 1001 SHR logical
  - 1010 MUL (optional feature)
  - All other codes are illegal.
- Compares are unsigned. Flags not defined for an op are 0. result is 0 for compare and illegal ops.
- States:
  - IDLE: in_ready=1. On accept of a single-cycle or illegal op, go to DONE. On accept of a shift, amt = min(op2, WIDTH). If amt==0, go to DONE with result=op1. Otherwise load counter=amt and go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, shift the working register by 1 in the selected direction, zero-fill, and decrement the counter. When the counter reaches 1, the final shift lands and the state moves to DONE.
  - DONE: out_valid=1; result and flags are held stable until out_ready. If out_ready, go to IDLE. in_ready = out_ready in DONE, so a new op can be accepted in the same cycle the result is consumed; that op then follows the IDLE accept rules.
- Latency, measured from the accept edge to out_valid high:
  - Single-cycle and illegal ops: 1 cycle.
  - Shift: 1 + amt cycles (amt saturated at WIDTH).
  - Any shift amount >= WIDTH gives result 0 after WIDTH+1 cycles.
- Arithmetic wraps modulo 2^WIDTH; there is no overflow flag.
- Backpressure: while out_valid && !out_ready, all outputs are frozen.
- Reset asserted mid-BUSY or mid-DONE aborts the op. Outputs go to reset values immediately; the result is lost.
- Throughput: one single-cycle op per clock when out_ready is held high.

Optional Feature:
ALU_MUL_EN:
- Defined: Aluop 1010 performs an unsigned iterative shift-add multiply.
  - WIDTH iterations in BUSY, one multiplier bit per cycle.
  - result = low WIDTH bits of op1*op2; carry = OR of the discarded high WIDTH bits.
  - Latency WIDTH+1 cycles regardless of operand values.
- Undefined: 1010 is illegal, giving result 0 and flags 0 with latency 1. No multiply logic is synthesised.

Test Plan:
- ADD op1=0xF0, op2=0x20, out_ready=1 -> next cycle out_valid=1, result=0x10, carry=1; SUB 0x05-0x07 -> result 0xFE, carry=1.
- SHL op1=0x81, op2=3 -> in_ready=0 for 3 cycles, out_valid at accept+4, result=0x08. SHR op1=0x81, op2=0 -> result 0x81 at accept+1.
- SHR op1=0xFF, op2=0x09 -> saturates to 8 iterations, result=0x00 at accept+9.
- SLTE op1=op2=0x3C -> lessThan=1, equal=1, result=0x00. Then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; on release, a back-to-back accept happens in the same cycle.
- Reset asserted on cycle 2 of SHL op2=6 -> out_valid=0, result=0 asynchronously; in_ready=1 after reset release; the old result never appears.
- With ALU_MUL_EN: 13*11 -> result 0x8F, carry=0, at accept+9; 0x10*0x10 -> result 0x00, carry=1. Without ALU_MUL_EN: 1010 -> result 0x00, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one-cycle logic/arith/compare ops, shifts one bit per cycle.
// Define ALU_MUL_EN to compile in the iterative shift-add multiply on Aluop 1010.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       Aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal,
    output logic             lessThan,
    output logic             carry,
    output logic [1:0]       stateDbg
);
    // Handshake: an op is taken on a rising edge with in_valid && in_ready; a result is
    // taken on a rising edge with out_valid && out_ready and is held unchanged until then.

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateT;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTE = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    localparam logic [WIDTH-1:0] WIDTH_OP = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext, amt;
    logic [3:0]       opReg, opNext;
    logic [WIDTH-1:0] resNext;
    logic             eqNext, ltNext, cyNext;
    logic             accept;
    logic [WIDTH:0]   sum;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mulHi, mulHiNext, mulCand, mulCandNext;
    logic [WIDTH:0]   mulSum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        opNext    = opReg;
        resNext   = result;
        eqNext    = equal;
        ltNext    = lessThan;
        cyNext    = carry;
        in_ready  = 1'b0;
        amt       = '0;
        sum       = '0;
`ifdef ALU_MUL_EN
        mulHiNext   = mulHi;
        mulCandNext = mulCand;
        mulSum      = '0;
`endif
        case (state)
            IDLE: in_ready = 1'b1;
            BUSY: begin
                cntNext = cnt - CNT_ONE;
                if (opReg == OP_SHL) resNext = result << 1;
                else if (opReg == OP_SHR) resNext = result >> 1;
`ifdef ALU_MUL_EN
                else if (opReg == OP_MUL) begin
                    // Product lives in {mulHi, result}; multiplier bits retire from the LSB.
                    mulSum = {1'b0, mulHi} + {1'b0, (result[0] ? mulCand : '0)};
                    {mulHiNext, resNext} = {mulSum, result[WIDTH-1:1]};
                    cyNext = |mulHiNext;
                end
`endif
                if (cnt == CNT_ONE) stateNext = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            opNext    = Aluop;
            resNext   = '0;
            eqNext    = 1'b0;
            ltNext    = 1'b0;
            cyNext    = 1'b0;
            stateNext = DONE;
            sum       = {1'b0, op1} + {1'b0, op2};
            case (Aluop)
                OP_AND:  resNext = op1 & op2;
                OP_OR:   resNext = op1 | op2;
                OP_XOR:  resNext = op1 ^ op2;
                OP_ADD:  {cyNext, resNext} = sum;
                OP_SUB: begin
                    resNext = op1 - op2;
                    cyNext  = op1 < op2;
                end
                OP_SLT:  ltNext = op1 < op2;
                OP_SLTE: begin
                    ltNext = op1 <= op2;
                    eqNext = op1 == op2;
                end
                OP_EQ:   eqNext = op1 == op2;
                OP_SHL, OP_SHR: begin
                    amt     = (op2 >= WIDTH_OP) ? CNT_FULL : op2[CNT_W-1:0];
                    resNext = op1;
                    if (amt != '0) begin
                        cntNext   = amt;
                        stateNext = BUSY;
                    end
                end
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    resNext     = op2;
                    mulHiNext   = '0;
                    mulCandNext = op1;
                    cntNext     = CNT_FULL;
                    stateNext   = BUSY;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            opReg    <= '0;
            result   <= '0;
            equal    <= 1'b0;
            lessThan <= 1'b0;
            carry    <= 1'b0;
`ifdef ALU_MUL_EN
            mulHi    <= '0;
            mulCand  <= '0;
`endif
        end else begin
            cnt      <= cntNext;
            opReg    <= opNext;
            result   <= resNext;
            equal    <= eqNext;
            lessThan <= ltNext;
            carry    <= cyNext;
`ifdef ALU_MUL_EN
            mulHi    <= mulHiNext;
            mulCand  <= mulCandNext;
`endif
        end
    end

    assign out_valid = (state == DONE);
    assign stateDbg  = state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model plus scoreboard, directed vectors with
// literal expectations. Follows ALU_MUL_EN the same way as the design.
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op1, op2;
    logic [3:0] Aluop;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       equal, lessThan, carry;
    logic [1:0] stateDbg;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit shown  = 0;

    logic [10:0] expQ[$];
    int          expCycleQ[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .Aluop(Aluop), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .equal(equal),
        .lessThan(lessThan), .carry(carry), .stateDbg(stateDbg)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // ---- reference model: result/flags from plain arithmetic, latency in cycles ----
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [10:0] e, output int lat);
        int amt, wide;
        logic [7:0] r;
        logic eq, lt, cy;
        r = 8'h00; eq = 1'b0; lt = 1'b0; cy = 1'b0; lat = 1; wide = 0;
        amt = (b > 8'd8) ? 8 : int'(b);
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            4'h3: begin wide = int'(a) + int'(b); r = wide[7:0]; cy = wide > 255; end
            4'h4: begin wide = int'(a) - int'(b) + 256; r = wide[7:0]; cy = a < b; end
            4'h5: lt = a < b;
            4'h6: begin lt = a <= b; eq = a == b; end
            4'h7: eq = a == b;
            4'h8: begin wide = int'(a) * (1 << amt); r = wide[7:0]; lat = 1 + amt; end
            4'h9: begin wide = int'(a) / (1 << amt); r = wide[7:0]; lat = 1 + amt; end
`ifdef ALU_MUL_EN
            4'hA: begin wide = int'(a) * int'(b); r = wide[7:0]; cy = wide > 255; lat = 9; end
`endif
            default: ;
        endcase
        e = {r, eq, lt, cy};
    endfunction

    // ---- driver: hold op until accepted, then scramble inputs and record expectation ----
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int waits);
        logic rdy;
        bit done;
        int startCyc, lat;
        logic [10:0] e;
        waits = 0; rdy = 1'b0; done = 0; startCyc = 0;
        in_valid = 1'b1; Aluop = op; op1 = a; op2 = b;
        while (!done) begin
            #1;
            rdy = in_ready;
            startCyc = cycle;
            @(negedge clk);
            if (rdy || waits >= 200) done = 1;
            else waits++;
        end
        in_valid = 1'b0;
        Aluop = 4'($urandom_range(0, 15));
        op1 = 8'($urandom_range(0, 255));
        op2 = 8'($urandom_range(0, 255));
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL issue_timeout op=%h got in_ready=0 required 1 within 200 cycles", op);
        end else begin
            model(op, a, b, e, lat);
            expQ.push_back(e);
            expCycleQ.push_back(startCyc + lat);
        end
    endtask

    task automatic expectOut(input string name, input logic v, input logic [7:0] r,
                             input logic eq, input logic lt, input logic cy);
        #2;
        checks++;
        if ({out_valid, result, equal, lessThan, carry} !== {v, r, eq, lt, cy}) begin
            errors++;
            $display("FAIL %s got v=%b r=%h eq=%b lt=%b cy=%b required v=%b r=%h eq=%b lt=%b cy=%b",
                     name, out_valid, result, equal, lessThan, carry, v, r, eq, lt, cy);
        end
    endtask

    task automatic expectBit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", name, got, req);
        end
    endtask

    // ---- scoreboard: every cycle out_valid is high, compare against the queue head ----
    always @(negedge clk) begin
        #2;
        if (reset !== 1'b1) begin
            if (out_valid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid got r=%h with no op outstanding", result);
                end else begin
                    if ({result, equal, lessThan, carry} !== expQ[0]) begin
                        errors++;
                        $display("FAIL sb_result got %h required %h (r,eq,lt,cy)",
                                 {result, equal, lessThan, carry}, expQ[0]);
                    end
                    if (!shown) begin
                        checks++;
                        if (cycle != expCycleQ[0]) begin
                            errors++;
                            $display("FAIL sb_latency got cycle %0d required %0d", cycle, expCycleQ[0]);
                        end
                        shown = 1;
                    end
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        void'(expCycleQ.pop_front());
                        shown = 0;
                    end
                end
            end else if (expQ.size() > 0 && !shown && cycle > expCycleQ[0]) begin
                checks++; errors++;
                $display("FAIL sb_late got no out_valid at cycle %0d required by %0d", cycle, expCycleQ[0]);
                void'(expQ.pop_front());
                void'(expCycleQ.pop_front());
            end
        end
    end

    // ---- directed stimulus ----
    logic [19:0] oneCyc [13] = '{
        20'h0_A5_3C, 20'h1_A5_3C, 20'h2_A5_3C, 20'h7_3C_3C, 20'h7_3C_3D,
        20'h5_01_02, 20'h5_02_02, 20'h6_03_02, 20'h6_02_03, 20'h3_FF_01,
        20'h4_07_05, 20'hB_12_34, 20'hF_FF_FF
    };
    logic [19:0] shVec [6] = '{
        20'h8_01_01, 20'h8_FF_07, 20'h8_FF_08, 20'h9_80_07, 20'h9_AA_C8, 20'h8_5A_00
    };

    initial begin
        int w, seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op1 = 8'h00; op2 = 8'h00; Aluop = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        expectOut("reset_outputs", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        expectBit("reset_state_idle", stateDbg == 2'd0, 1'b1);
        @(negedge clk); reset = 1'b0;
        #1 expectBit("ready_after_reset", in_ready, 1'b1);
        @(negedge clk);

        issue(4'h3, 8'hF0, 8'h20, w);
        expectOut("add_f0_20", 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        issue(4'h4, 8'h05, 8'h07, w);
        expectOut("sub_05_07", 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);

        foreach (oneCyc[i]) begin
            issue(oneCyc[i][19:16], oneCyc[i][15:8], oneCyc[i][7:0], w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL throughput op=%h got %0d stall cycles required 0", oneCyc[i][19:16], w);
            end
        end

        @(negedge clk);
        issue(4'h8, 8'h81, 8'h03, w);
        for (int i = 0; i < 3; i++) begin
            #2;
            expectBit("shl_busy_in_ready", in_ready, 1'b0);
            expectBit("shl_busy_out_valid", out_valid, 1'b0);
            @(negedge clk);
        end
        expectOut("shl_81_3", 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        issue(4'h9, 8'h81, 8'h00, w);
        expectOut("shr_81_0", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        issue(4'h9, 8'hFF, 8'h09, w);
        repeat (8) @(negedge clk);
        expectOut("shr_ff_9_sat", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        foreach (shVec[i]) issue(shVec[i][19:16], shVec[i][15:8], shVec[i][7:0], w);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);

        // Backpressure then same-edge consume + accept.
        @(negedge clk); out_ready = 1'b0;
        issue(4'h6, 8'h3C, 8'h3C, w);
        expectOut("slte_3c_3c", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expectOut("slte_hold", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
            expectBit("hold_in_ready", in_ready, 1'b0);
        end
        @(negedge clk); out_ready = 1'b1;
        issue(4'h0, 8'hF0, 8'h3C, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL b2b_accept got %0d stall cycles required 0", w);
        end
        expectOut("and_b2b", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);

        // Reset during a shift aborts it.
        @(negedge clk);
        issue(4'h8, 8'h81, 8'h06, w);
        @(negedge clk);
        reset = 1'b1;
        expQ.delete(); expCycleQ.delete(); shown = 0;
        #1;
        expectOut("reset_mid_busy", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        #1 expectBit("ready_after_abort", in_ready, 1'b1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            #2 if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL aborted_result got %0d valid cycles required 0", seen);
        end

        @(negedge clk);
`ifdef ALU_MUL_EN
        issue(4'hA, 8'h0D, 8'h0B, w);
        repeat (8) @(negedge clk);
        expectOut("mul_13_11", 1'b1, 8'h8F, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(4'hA, 8'h10, 8'h10, w);
        repeat (8) @(negedge clk);
        expectOut("mul_10_10", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
`else
        issue(4'hA, 8'h12, 8'h34, w);
        expectOut("mul_illegal", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 100 && expQ.size() > 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d results outstanding required 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
